// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU op codes, FSM state codes and the bundled control word.
package mips_mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_NOR    = 4'd5;
  localparam logic [3:0] ALU_SLT    = 4'd6;
  localparam logic [3:0] ALU_SLTU   = 4'd7;
  localparam logic [3:0] ALU_SLL    = 4'd8;
  localparam logic [3:0] ALU_SRL    = 4'd9;
  localparam logic [3:0] ALU_SRA    = 4'd10;
  localparam logic [3:0] ALU_LUI    = 4'd11;
  localparam logic [3:0] ALU_PASS_B = 4'd12;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_EXEC_I   = 4'd3;
  localparam logic [3:0] ST_WB_R     = 4'd4;
  localparam logic [3:0] ST_WB_I     = 4'd5;
  localparam logic [3:0] ST_MEM_ADDR = 4'd6;
  localparam logic [3:0] ST_MEM_RD   = 4'd7;
  localparam logic [3:0] ST_WB_MEM   = 4'd8;
  localparam logic [3:0] ST_MEM_WR   = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;
  localparam logic [3:0] ST_ILLEGAL  = 4'd12;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [4:0] shamt;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> IR/memory/ALU datapath bundle. master = controller side.
interface mips_mc_ctrl_if;
  import mips_mc_ctrl_pkg::*;

  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  shamt;
  logic        illegal;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, shamt, illegal
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, shamt, illegal
  );
endinterface

// File: rtl/mips_mc_ctrl_alu_op_decode.sv
// Combinational {opcode, funct} -> ALU op code, plus a flag saying the
// instruction is one this controller supports.
module alu_op_decode
  import mips_mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB:          alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_XOR:          alu_ctrl = ALU_XOR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          FN_SLTU:         alu_ctrl = ALU_SLTU;
          FN_SLL:          alu_ctrl = ALU_SLL;
          FN_SRL:          alu_ctrl = ALU_SRL;
          FN_SRA:          alu_ctrl = ALU_SRA;
          default:         legal    = 1'b0;
        endcase
      end
      OP_ADDI:              alu_ctrl = ALU_ADD;
      OP_ANDI:              alu_ctrl = ALU_AND;
      OP_ORI:               alu_ctrl = ALU_OR;
      OP_SLTI:              alu_ctrl = ALU_SLT;
      OP_LUI:               alu_ctrl = ALU_LUI;
      OP_LW, OP_SW, OP_J:   alu_ctrl = ALU_ADD;
      OP_BEQ, OP_BNE:       alu_ctrl = ALU_SUB;
      default:              legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, memory wait counter and
// Moore-style output decode (fetch/memory strobes also qualified by mem_ready).
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  localparam int TO_M1 = MEM_TIMEOUT - 1;

  logic [3:0] state, state_nxt;
  logic       run;
  logic [4:0] wcnt;
  logic [5:0] opcode, funct;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       wait_st, timeout;
  ctrl_t      c;
  logic       unused_instr;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:11];

  alu_op_decode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  assign wait_st = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  assign timeout = (MEM_TIMEOUT != 0) && ({27'd0, wcnt} >= 32'(TO_M1));

  always_comb begin
    state_nxt = state;
    if (run) begin
      case (state)
        ST_FETCH:    if (bus.mem_ready) state_nxt = ST_DECODE;
                     else if (timeout)  state_nxt = ST_ILLEGAL;
        ST_DECODE: begin
          if (!dec_legal) state_nxt = ST_ILLEGAL;
          else begin
            case (opcode)
              OP_RTYPE:                               state_nxt = ST_EXEC_R;
              OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_nxt = ST_EXEC_I;
              OP_LW, OP_SW:                           state_nxt = ST_MEM_ADDR;
              OP_BEQ, OP_BNE:                         state_nxt = ST_BRANCH;
              OP_J:                                   state_nxt = ST_JUMP;
              default:                                state_nxt = ST_ILLEGAL;
            endcase
          end
        end
        ST_EXEC_R:   state_nxt = ST_WB_R;
        ST_EXEC_I:   state_nxt = ST_WB_I;
        ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_nxt = ST_FETCH;
        ST_MEM_ADDR: state_nxt = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   if (bus.mem_ready) state_nxt = ST_WB_MEM;
                     else if (timeout)  state_nxt = ST_ILLEGAL;
        ST_MEM_WR:   if (bus.mem_ready) state_nxt = ST_FETCH;
                     else if (timeout)  state_nxt = ST_ILLEGAL;
        default:     state_nxt = ST_ILLEGAL;
      endcase
    end
  end

  // run stays low for the cycle reset is sampled in, so a reset mid-request
  // drops mem_req immediately and the FSM idles in FETCH until rst falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      run   <= 1'b0;
      wcnt  <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      if (state_nxt != state)
        wcnt <= '0;
      else if (run && wait_st && !bus.mem_ready && wcnt != 5'h1f)
        wcnt <= wcnt + 5'd1;
    end
  end

  always_comb begin
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    if (run) begin
      case (state)
        ST_FETCH: begin
          c.mem_req   = 1'b1;
          c.alu_src_b = 2'd1;
          c.ir_write  = bus.mem_ready;
          c.pc_write  = bus.mem_ready;
        end
        ST_DECODE:   c.alu_src_b = 2'd3;
        ST_EXEC_R: begin
          c.alu_src_a = 1'b1;
          c.alu_ctrl  = dec_alu;
          c.shamt     = bus.instr[10:6];
        end
        ST_EXEC_I: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'd2;
          c.alu_ctrl  = dec_alu;
        end
        ST_WB_R: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
        end
        ST_WB_I:     c.reg_write = 1'b1;
        ST_MEM_ADDR: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'd2;
        end
        ST_MEM_RD: begin
          c.mem_req = 1'b1;
          c.iord    = 1'b1;
        end
        ST_WB_MEM: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        ST_MEM_WR: begin
          c.mem_req = 1'b1;
          c.mem_we  = 1'b1;
          c.iord    = 1'b1;
        end
        ST_BRANCH: begin
          c.alu_src_a = 1'b1;
          c.alu_ctrl  = ALU_SUB;
          c.pc_src    = 2'd1;
          c.pc_write  = (opcode == OP_BNE) ? ~bus.zero : bus.zero;
        end
        ST_JUMP: begin
          c.pc_src   = 2'd2;
          c.pc_write = 1'b1;
        end
        ST_ILLEGAL:  c.illegal = 1'b1;
        default:     c.illegal = 1'b1;
      endcase
    end
  end

  assign bus.mem_req    = c.mem_req;
  assign bus.mem_we     = c.mem_we;
  assign bus.iord       = c.iord;
  assign bus.ir_write   = c.ir_write;
  assign bus.pc_write   = c.pc_write;
  assign bus.pc_src     = c.pc_src;
  assign bus.reg_write  = c.reg_write;
  assign bus.reg_dst    = c.reg_dst;
  assign bus.mem_to_reg = c.mem_to_reg;
  assign bus.alu_src_a  = c.alu_src_a;
  assign bus.alu_src_b  = c.alu_src_b;
  assign bus.alu_ctrl   = c.alu_ctrl;
  assign bus.shamt      = c.shamt;
  assign bus.illegal    = c.illegal;

endmodule
